// File: rtl/alu_shift_pkg.sv
// Shared types and constants for the shift arbiter and its shift unit.
// Optional build macro: SHIFT_ARB_ROR_EN enables rotate-right for op=11.
package alu_shift_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

    // Rotate right: bits leaving the LSB re-enter at the MSB.
    function automatic logic [DATA_W-1:0] rotr(
        input logic [DATA_W-1:0]  a,
        input logic [SHAMT_W-1:0] s
    );
        logic [2*DATA_W-1:0] doubled;
        doubled = {a, a} >> s;
        return doubled[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/shift_unit_8bit.sv
// Purely combinational 8-bit shifter: SLL, SRL, SRA and op=11.
// With SHIFT_ARB_ROR_EN defined op=11 rotates right, otherwise it
// passes the operand through unchanged.
module shift_unit_8bit
    import alu_shift_pkg::*;
(
    input  logic [DATA_W-1:0]  a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_t          op_i,
    output logic [DATA_W-1:0]  y_o
);

    // Select the shift result for the requested operation.
    always_comb begin
        y_o = a_i;
        unique case (op_i)
            OP_SLL: y_o = a_i << shamt_i;
            OP_SRL: y_o = a_i >> shamt_i;
            OP_SRA: y_o = $signed(a_i) >>> shamt_i;
            OP_ROR: begin
`ifdef SHIFT_ARB_ROR_EN
                y_o = rotr(a_i, shamt_i);
`else
                y_o = a_i;
`endif
            end
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/shift_arbiter_8bit.sv
// Round-robin arbiter sharing one 8-bit shift unit among NUM_REQ
// requesters. A grant latches the operands, the next cycle executes and
// registers the result, which is then held until the consumer accepts it.
// Optional build macro: SHIFT_ARB_ROR_EN (op=11 rotate-right vs passthrough).
module shift_arbiter_8bit
    import alu_shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*SHAMT_W-1:0]  req_shamt,
    input  logic [NUM_REQ*2-1:0]        req_op,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy
);

    arb_state_t          state_q,     state_d;
    logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [DATA_W-1:0]   a_q,         a_d;
    logic [SHAMT_W-1:0]  shamt_q,     shamt_d;
    shift_op_t           op_q,        op_d;
    logic [ID_W-1:0]     id_q,        id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;

    logic                grant_valid;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     grant_next;
    logic [DATA_W-1:0]   sel_a;
    logic [SHAMT_W-1:0]  sel_shamt;
    shift_op_t           sel_op;
    logic [DATA_W-1:0]   shift_y;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [ID_W:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_valid && req_valid[cand[ID_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Pointer value that follows the granted requester, modulo NUM_REQ.
    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            grant_next = '0;
        end else begin
            grant_next = grant_idx + 1'b1;
        end
    end

    // Pick the granted requester's operands out of the flattened buses.
    always_comb begin
        sel_a     = '0;
        sel_shamt = '0;
        sel_op    = OP_SLL;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a     = req_a[i*DATA_W +: DATA_W];
                sel_shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
                sel_op    = shift_op_t'(req_op[i*2 +: 2]);
            end
        end
    end

    shift_unit_8bit u_shift (
        .a_i     (a_q),
        .shamt_i (shamt_q),
        .op_i    (op_q),
        .y_o     (shift_y)
    );

    // Next-state and handshake logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        shamt_d     = shamt_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        req_ready   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (grant_idx == ID_W'(i));
                    end
                    a_d      = sel_a;
                    shamt_d  = sel_shamt;
                    op_d     = sel_op;
                    id_d     = grant_idx;
                    rr_ptr_d = grant_next;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = shift_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, operand and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            shamt_q     <= '0;
            op_q        <= OP_SLL;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            shamt_q     <= shamt_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
